// File: rtl/debug_loader.sv
// Byte-stream program loader: parses HEADER/address/count/data frames from a serial
// receiver and writes 32-bit words into instruction memory through a registered strobe.
module debug_loader #(
  parameter logic [7:0]  HEADER    = 8'hA5,
  parameter int unsigned MAX_WORDS = 16384,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        DEBUG_SIG,
  output logic [31:0] DEBUG_addr,
  output logic [31:0] DEBUG_instr,
  output logic        clk_debug,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] words_written
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_COUNT  = 3'd2,
    ST_DATA   = 3'd3,
    ST_SETUP  = 3'd4,
    ST_STROBE = 3'd5,
    ST_FINISH = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [31:0] tmo_q, tmo_d;
  logic        rx_ready_q, rx_ready_d;
  logic        dbg_sig_q, dbg_sig_d;
  logic [31:0] dbg_addr_q, dbg_addr_d;
  logic [31:0] dbg_instr_q, dbg_instr_d;
  logic        clk_debug_q, clk_debug_d;
  logic        load_done_q, load_done_d;
  logic        load_err_q, load_err_d;
  logic [15:0] words_q, words_d;

  logic        accept_s;
  logic        tmo_expired_s;
  logic [31:0] addr_shift_s;
  logic [15:0] cnt_shift_s;
  logic [31:0] word_shift_s;

  // Little-endian assembly: each byte enters at the top, so the first byte ends up lowest.
  assign accept_s      = rx_valid && rx_ready_q;
  assign tmo_expired_s = (tmo_q >= (TIMEOUT - 32'd1));
  assign addr_shift_s  = {rx_data, addr_q[31:8]};
  assign cnt_shift_s   = {rx_data, cnt_q[15:8]};
  assign word_shift_s  = {rx_data, word_q[31:8]};

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    bidx_d      = bidx_q;
    tmo_d       = 32'd0;
    words_d     = words_q;
    load_err_d  = load_err_q;
    dbg_addr_d  = dbg_addr_q;
    dbg_instr_d = dbg_instr_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s && (rx_data == HEADER)) begin
          state_d    = ST_ADDR;
          bidx_d     = 2'd0;
          words_d    = 16'd0;
          load_err_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (accept_s) begin
          addr_d = addr_shift_s;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            if (addr_shift_s[1:0] != 2'b00) state_d = ST_ERROR;
            else                            state_d = ST_COUNT;
          end else begin
            state_d = ST_ADDR;
          end
        end else if (tmo_expired_s) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      ST_COUNT: begin
        if (accept_s) begin
          cnt_d  = cnt_shift_s;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q[0]) begin
            bidx_d = 2'd0;
            if (cnt_shift_s == 16'd0)                         state_d = ST_FINISH;
            else if ({16'd0, cnt_shift_s} > 32'(MAX_WORDS))   state_d = ST_ERROR;
            else                                              state_d = ST_DATA;
          end else begin
            state_d = ST_COUNT;
          end
        end else if (tmo_expired_s) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          word_d = word_shift_s;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            // Present address/word during SETUP so they are stable a full cycle before the strobe.
            state_d     = ST_SETUP;
            dbg_addr_d  = addr_q;
            dbg_instr_d = word_shift_s;
          end else begin
            state_d = ST_DATA;
          end
        end else if (tmo_expired_s) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        addr_d  = addr_q + 32'd4;
        cnt_d   = cnt_q - 16'd1;
        words_d = words_q + 16'd1;
        if (cnt_q == 16'd1) state_d = ST_FINISH;
        else                state_d = ST_DATA;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    load_err_d  = load_err_d | (state_d == ST_ERROR);
    rx_ready_d  = (state_d == ST_IDLE) || (state_d == ST_ADDR) ||
                  (state_d == ST_COUNT) || (state_d == ST_DATA);
    dbg_sig_d   = (state_d == ST_ADDR) || (state_d == ST_COUNT) || (state_d == ST_DATA) ||
                  (state_d == ST_SETUP) || (state_d == ST_STROBE);
    clk_debug_d = (state_d == ST_STROBE);
    load_done_d = (state_d == ST_FINISH);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= 32'd0;
      cnt_q       <= 16'd0;
      word_q      <= 32'd0;
      bidx_q      <= 2'd0;
      tmo_q       <= 32'd0;
      rx_ready_q  <= 1'b1;
      dbg_sig_q   <= 1'b0;
      dbg_addr_q  <= 32'd0;
      dbg_instr_q <= 32'd0;
      clk_debug_q <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      words_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      bidx_q      <= bidx_d;
      tmo_q       <= tmo_d;
      rx_ready_q  <= rx_ready_d;
      dbg_sig_q   <= dbg_sig_d;
      dbg_addr_q  <= dbg_addr_d;
      dbg_instr_q <= dbg_instr_d;
      clk_debug_q <= clk_debug_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      words_q     <= words_d;
    end
  end

  assign rx_ready      = rx_ready_q;
  assign DEBUG_SIG     = dbg_sig_q;
  assign DEBUG_addr    = dbg_addr_q;
  assign DEBUG_instr   = dbg_instr_q;
  assign clk_debug     = clk_debug_q;
  assign load_done     = load_done_q;
  assign load_err      = load_err_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_debug_loader.sv
// Directed bench for debug_loader: frames are driven byte by byte, expected memory
// writes are queued on send and popped by a monitor at each clk_debug strobe.
module tb_debug_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        DEBUG_SIG;
  logic [31:0] DEBUG_addr;
  logic [31:0] DEBUG_instr;
  logic        clk_debug;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_written;

  always #5 clk = ~clk;

  debug_loader #(.HEADER(8'hA5), .MAX_WORDS(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .DEBUG_SIG(DEBUG_SIG), .DEBUG_addr(DEBUG_addr), .DEBUG_instr(DEBUG_instr),
    .clk_debug(clk_debug), .load_done(load_done), .load_err(load_err),
    .words_written(words_written)
  );

  typedef struct packed {logic [31:0] a; logic [31:0] d;} wr_t;
  wr_t         exp_q[$];
  logic [31:0] frame_w[$];
  int checks = 0, errors = 0;
  int strobe_cnt = 0, done_cnt = 0, sig_cycles = 0, hold_cycles = 0;
  int s0, d0, g0, h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor: SETUP shows the next queued write, STROBE consumes it
  always @(negedge clk) begin
    wr_t w;
    if (!rst) begin
      if (DEBUG_SIG) sig_cycles++;
      if (load_done) done_cnt++;
      if (DEBUG_SIG && !rx_ready) hold_cycles++;
      if (DEBUG_SIG && !rx_ready && !clk_debug) begin
        check("setup_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check("setup_addr", DEBUG_addr, exp_q[0].a);
          check("setup_instr", DEBUG_instr, exp_q[0].d);
        end
      end
      if (clk_debug) begin
        strobe_cnt++;
        check("strobe_rx_ready", 32'(rx_ready), 32'd0);
        check("strobe_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("strobe_addr", DEBUG_addr, w.a);
          check("strobe_instr", DEBUG_instr, w.d);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic rx_stop();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [15:0] n, input bit push);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    foreach (frame_w[k]) begin
      if (push) exp_q.push_back({a + 32'(4 * k), frame_w[k]});
      for (int j = 0; j < 4; j++) send_byte(frame_w[k][8*j +: 8]);
    end
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_sig", 32'(DEBUG_SIG), 32'd0);
    check("rst_strobe", 32'(clk_debug), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_words", 32'(words_written), 32'd0);
    check("rst_addr", DEBUG_addr, 32'd0);
    check("rst_instr", DEBUG_instr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Two-word frame at 0x1000
    s0 = strobe_cnt; d0 = done_cnt;
    frame_w = {32'h00000013, 32'h00100093};
    send_frame(32'h00001000, 16'd2, 1'b1);
    rx_stop(); settle(8);
    check("A_strobes", strobe_cnt - s0, 32'd2);
    check("A_done", done_cnt - d0, 32'd1);
    check("A_words", 32'(words_written), 32'd2);
    check("A_err", 32'(load_err), 32'd0);
    check("A_sig", 32'(DEBUG_SIG), 32'd0);
    check("A_queue", exp_q.size(), 32'd0);
    check("A_hold_addr", DEBUG_addr, 32'h00001004);
    check("A_hold_instr", DEBUG_instr, 32'h00100093);

    // Misaligned address
    s0 = strobe_cnt; d0 = done_cnt;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("B_err_now", 32'(load_err), 32'd1);
    check("B_sig_now", 32'(DEBUG_SIG), 32'd0);
    check("B_ready_now", 32'(rx_ready), 32'd0);
    rx_stop(); settle(4);
    check("B_err_sticky", 32'(load_err), 32'd1);
    check("B_strobes", strobe_cnt - s0, 32'd0);
    check("B_done", done_cnt - d0, 32'd0);
    check("B_ready_idle", 32'(rx_ready), 32'd1);

    // Zero-length frame
    s0 = strobe_cnt; d0 = done_cnt; g0 = sig_cycles;
    frame_w = {};
    send_frame(32'h00000000, 16'd0, 1'b0);
    rx_stop(); settle(4);
    check("C_sig_cycles", sig_cycles - g0, 32'd6);
    check("C_done", done_cnt - d0, 32'd1);
    check("C_strobes", strobe_cnt - s0, 32'd0);
    check("C_err_cleared", 32'(load_err), 32'd0);
    check("C_words", 32'(words_written), 32'd0);

    // Address wrap
    s0 = strobe_cnt;
    frame_w = {32'hDEADBEEF, 32'hCAFEF00D};
    send_frame(32'hFFFFFFFC, 16'd2, 1'b1);
    rx_stop(); settle(6);
    check("D_strobes", strobe_cnt - s0, 32'd2);
    check("D_words", 32'(words_written), 32'd2);
    check("D_addr", DEBUG_addr, 32'h00000000);
    check("D_err", 32'(load_err), 32'd0);

    // Junk byte then back-to-back frame with rx_valid held high
    s0 = strobe_cnt; d0 = done_cnt; h0 = hold_cycles;
    send_byte(8'h55);
    check("E_junk_ignored", 32'(DEBUG_SIG), 32'd0);
    frame_w = {32'h11223344, 32'hA5A5A5A5, 32'h0BADF00D};
    send_frame(32'h00000200, 16'd3, 1'b1);
    rx_stop(); settle(6);
    check("E_strobes", strobe_cnt - s0, 32'd3);
    check("E_done", done_cnt - d0, 32'd1);
    check("E_hold_cycles", hold_cycles - h0, 32'd6);
    check("E_words", 32'(words_written), 32'd3);
    check("E_queue", exp_q.size(), 32'd0);

    // Count at MAX_WORDS is legal, one more is an error
    s0 = strobe_cnt;
    frame_w = {};
    for (int i = 0; i < 8; i++) frame_w.push_back($urandom);
    send_frame(32'h00000400, 16'd8, 1'b1);
    rx_stop(); settle(6);
    check("F_max_strobes", strobe_cnt - s0, 32'd8);
    check("F_max_words", 32'(words_written), 32'd8);
    s0 = strobe_cnt; d0 = done_cnt;
    frame_w = {};
    send_frame(32'h00000500, 16'd9, 1'b0);
    rx_stop(); settle(4);
    check("F_over_err", 32'(load_err), 32'd1);
    check("F_over_strobes", strobe_cnt - s0, 32'd0);
    check("F_over_done", done_cnt - d0, 32'd0);
    check("F_over_words", 32'(words_written), 32'd0);

    // Stall after the second data byte
    s0 = strobe_cnt;
    frame_w = {};
    send_frame(32'h00000100, 16'd2, 1'b0);
    send_byte(8'h11); send_byte(8'h22);
    rx_stop();
    repeat (15) @(posedge clk);
    #1;
    check("G_no_err_early", 32'(load_err), 32'd0);
    check("G_sig_early", 32'(DEBUG_SIG), 32'd1);
    @(posedge clk);
    #1;
    check("G_err", 32'(load_err), 32'd1);
    check("G_sig", 32'(DEBUG_SIG), 32'd0);
    check("G_ready", 32'(rx_ready), 32'd0);
    frame_w = {32'h12345678};
    send_frame(32'h00000300, 16'd1, 1'b1);
    rx_stop(); settle(6);
    check("G_strobes", strobe_cnt - s0, 32'd1);
    check("G_err_cleared", 32'(load_err), 32'd0);
    check("G_words", 32'(words_written), 32'd1);
    check("G_queue", exp_q.size(), 32'd0);

    // Reset in the middle of a data word
    s0 = strobe_cnt; d0 = done_cnt;
    frame_w = {};
    send_frame(32'h00000600, 16'd1, 1'b0);
    send_byte(8'h01); send_byte(8'h02);
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0;
    @(posedge clk);
    #1;
    check("H_sig", 32'(DEBUG_SIG), 32'd0);
    check("H_err", 32'(load_err), 32'd0);
    check("H_done", 32'(load_done), 32'd0);
    check("H_strobe", 32'(clk_debug), 32'd0);
    check("H_words", 32'(words_written), 32'd0);
    check("H_ready", 32'(rx_ready), 32'd1);
    check("H_addr", DEBUG_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    settle(4);
    check("H_no_strobe", strobe_cnt - s0, 32'd0);
    frame_w = {32'hA5A5A5A5};
    send_frame(32'h00000700, 16'd1, 1'b1);
    rx_stop(); settle(6);
    check("H_recover_strobes", strobe_cnt - s0, 32'd1);
    check("H_recover_done", done_cnt - d0, 32'd1);
    check("H_queue", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_loader.md
DEBUG_LOADER -- requirements
Module: debug_loader

Interface
REQ-001 Parameter HEADER, default 8'hA5: frame start byte.
REQ-002 Parameter MAX_WORDS, default 16384: largest legal word count per frame.
REQ-003 Parameter TIMEOUT, default 1000000: allowed idle cycles between bytes inside a frame.
REQ-004 clk  in  1  single block clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 rx_valid  in  1  byte available from serial receiver.
REQ-007 rx_data  in  8  received byte.
REQ-008 rx_ready  out  1  loader accepts a byte; transfer occurs when rx_valid && rx_ready.
REQ-009 DEBUG_SIG  out  1  holds core in program-load mode.
REQ-010 DEBUG_addr  out  32  instruction-memory byte address.
REQ-011 DEBUG_instr  out  32  instruction word.
REQ-012 clk_debug  out  1  registered write strobe to instruction memory.
REQ-013 load_done  out  1  one-cycle pulse when a frame completes.
REQ-014 load_err  out  1  sticky frame-error flag.
REQ-015 words_written  out  16  words written in current/last frame.

Function
REQ-016 Frame format: HEADER; 4 address bytes, little-endian; 2 count bytes N, little-endian; N x 4 instruction bytes, each word little-endian.
REQ-017 States: IDLE, ADDR, COUNT, DATA, SETUP, STROBE, FINISH, ERROR.
REQ-018 IDLE: rx_ready=1; HEADER byte -> ADDR, with DEBUG_SIG=1, load_err=0 and words_written=0 on the next cycle; any other byte is discarded.
REQ-019 ADDR: 4 bytes accepted; after the 4th byte, if addr[1:0]!=0 -> ERROR, else -> COUNT.
REQ-020 COUNT: 2 bytes accepted; N=0 -> FINISH; N>MAX_WORDS -> ERROR; else -> DATA.
REQ-021 DATA: 4 bytes assembled into a word; the 4th byte -> SETUP.
REQ-022 SETUP, 1 cycle: DEBUG_addr=current address; DEBUG_instr=assembled word; clk_debug=0.
REQ-023 STROBE, 1 cycle: clk_debug=1; DEBUG_addr and DEBUG_instr unchanged.
REQ-024 On leaving STROBE: address+=4, words_written+=1, remaining-=1; remaining==0 -> FINISH, else -> DATA.
REQ-025 DEBUG_addr and DEBUG_instr hold their values from SETUP until the next SETUP.
REQ-026 rx_ready=0 in SETUP, STROBE, FINISH and ERROR; rx_ready=1 in IDLE, ADDR, COUNT and DATA.
REQ-027 clk_debug is driven directly from a flop; it is high only in STROBE and never glitches.
REQ-028 FINISH, 1 cycle: load_done=1 and DEBUG_SIG=0 on the same cycle; -> IDLE.
REQ-029 ERROR, 1 cycle: load_err set, DEBUG_SIG=0, no strobe; -> IDLE.
REQ-030 Timeout counter: cleared on every accepted byte and on entry to ADDR; counts in ADDR, COUNT and DATA while no byte is accepted; reaching TIMEOUT -> ERROR.
REQ-031 Address increment wraps modulo 2^32 with no error.
REQ-032 Partial words are never written; an aborted frame leaves earlier written words intact.
REQ-033 A HEADER byte received in ADDR, COUNT or DATA is treated as data, not as a restart.
REQ-034 load_err stays high through IDLE and clears only on the next accepted HEADER.

Reset
REQ-035 While rst=1 at a clock edge: state=IDLE; all outputs, counters and assembly registers are 0, except rx_ready=1 from the first cycle after reset.
REQ-036 Reset mid-frame aborts the frame immediately: DEBUG_SIG=0, no clk_debug pulse, and load_done and load_err both 0.

Verification
REQ-037 Stimulus A5, 00 10 00 00, 02 00, 13 00 00 00, 93 00 10 00 -> two clk_debug pulses: addr 0x00001000 data 0x00000013, then addr 0x00001004 data 0x00100093; load_done pulses once; words_written=2.
REQ-038 Stimulus A5, 02 00 00 00 -> ERROR after the 4th address byte; load_err=1; DEBUG_SIG=0; no strobe.
REQ-039 Stimulus A5, addr 0x0, count 00 00 -> no strobe; load_done pulse; DEBUG_SIG high for exactly the frame duration.
REQ-040 Stimulus A5, addr 0xFFFFFFFC, N=2 -> writes to 0xFFFFFFFC then 0x00000000.
REQ-041 Bytes 55 then A5 then a valid frame, with rx_valid held high continuously -> 55 ignored; rx_ready low during SETUP and STROBE; no byte lost.
REQ-042 TIMEOUT=16 and a stall of 16 cycles after the 2nd data byte -> ERROR and load_err=1; a following fresh frame then loads correctly and clears load_err.
